// File: rtl/dmem_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_arb_pkg
//  Description : Shared constants and types for the data-memory port arbiter
//                and its round-robin picker.
//  Revision    : 1.0  initial release
// ============================================================================
package dmem_arb_pkg;

    // Requester slots on the shared data-memory port
    localparam int REQ_UART_RX = 0;
    localparam int REQ_PROC    = 1;
    localparam int REQ_UART_TX = 2;

    // Default geometry (DATA_W = CORE_COUNT * REG_WIDTH)
    localparam int DEF_N_REQ     = 3;
    localparam int DEF_ADDR_W    = 12;
    localparam int DEF_DATA_W    = 60;
    localparam int DEF_MAX_BURST = 16;

    typedef logic [$clog2(DEF_N_REQ)-1:0] req_idx_t;

endpackage : dmem_arb_pkg
`default_nettype wire

// File: rtl/dmem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_port_arbiter_if
//  Description : Requester-side bundle of the data-memory port arbiter.
//                master = requesters, slave = arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
interface dmem_port_arbiter_if
    import dmem_arb_pkg::*;
#(
    parameter int N_REQ  = DEF_N_REQ,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    logic [N_REQ-1:0]        en;
    logic [N_REQ-1:0]        req;
    logic [N_REQ-1:0]        lock;
    logic [N_REQ-1:0]        we;
    logic [N_REQ*ADDR_W-1:0] addr;
    logic [N_REQ*DATA_W-1:0] wdata;
    logic [N_REQ-1:0]        gnt;
    logic [N_REQ-1:0]        rvalid;
    logic [DATA_W-1:0]       rdata;
    logic                    busy;

    modport master (
        output en, req, lock, we, addr, wdata,
        input  gnt, rvalid, rdata, busy
    );

    modport slave (
        input  en, req, lock, we, addr, wdata,
        output gnt, rvalid, rdata, busy
    );
endinterface : dmem_port_arbiter_if
`default_nettype wire

// File: rtl/dmem_port_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick
//  Description : Combinational round-robin picker. Searches elig starting at
//                ptr+1 (mod N_REQ) and returns a one-hot pick plus its index.
//                The slot at ptr itself has the lowest priority.
//  Revision    : 1.0  initial release
// ============================================================================
module rr_pick
    import dmem_arb_pkg::*;
#(
    parameter  int N_REQ = DEF_N_REQ,
    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] elig,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] pick,
    output logic [IDX_W-1:0] pick_idx
);

    // Walk from lowest to highest priority so the closest hit after ptr wins
    always_comb begin
        pick     = '0;
        pick_idx = '0;
        for (int i = N_REQ; i >= 1; i--) begin
            if (elig[(int'(ptr) + i) % N_REQ]) begin
                pick                             = '0;
                pick[(int'(ptr) + i) % N_REQ]    = 1'b1;
                pick_idx                         = IDX_W'((int'(ptr) + i) % N_REQ);
            end
        end
    end

endmodule : rr_pick
`default_nettype wire

// File: rtl/dmem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_port_arbiter
//  Description : Shares the single-port data memory (1-cycle registered read)
//                among N_REQ requesters. Round-robin with burst lock and a
//                starvation cap; per-requester enable mask from the phase FSM.
//  Revision    : 1.0  initial release
// ============================================================================
module dmem_port_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int N_REQ     = DEF_N_REQ,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int MAX_BURST = DEF_MAX_BURST
) (
    input  logic                clk,
    input  logic                rst,
    dmem_port_arbiter_if.slave  bus,
    output logic                mem_wrEn,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_dataIn,
    input  logic [DATA_W-1:0]   mem_dataOut
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] BURST_CAP = CNT_W'(MAX_BURST - 1);

    logic [N_REQ-1:0] w_elig;
    logic [N_REQ-1:0] w_owner_oh;
    logic [N_REQ-1:0] w_rr_pick;
    logic [IDX_W-1:0] w_rr_idx;
    logic [N_REQ-1:0] w_gnt;
    logic [IDX_W-1:0] w_gnt_idx;
    logic [N_REQ-1:0] w_rvalid;
    logic             w_any;
    logic             w_others;
    logic             w_hold;

    logic [IDX_W-1:0]  r_ptr;
    logic [IDX_W-1:0]  r_owner;
    logic              r_lock_vld;
    logic [CNT_W-1:0]  r_burst_cnt;
    logic [ADDR_W-1:0] r_last_addr;
    logic [N_REQ-1:0]  r_rvalid;

    // Nothing is eligible while reset is asserted
    assign w_elig     = rst ? '0 : (bus.req & bus.en);
    assign w_owner_oh = N_REQ'(1) << r_owner;
    assign w_others   = |(w_elig & ~w_owner_oh);

    // Lock continues only while the owner stays eligible; the cap breaks it
    // for one arbitration when somebody else is waiting
    assign w_hold = r_lock_vld && w_elig[r_owner]
                    && !((r_burst_cnt >= BURST_CAP) && w_others);

    rr_pick #(
        .N_REQ    (N_REQ)
    ) u_rr_pick (
        .elig     (w_elig),
        .ptr      (r_ptr),
        .pick     (w_rr_pick),
        .pick_idx (w_rr_idx)
    );

    assign w_gnt     = w_hold ? w_owner_oh : w_rr_pick;
    assign w_gnt_idx = w_hold ? r_owner    : w_rr_idx;
    assign w_any     = |w_gnt;

    // Memory port follows the granted requester; address parks on last value
    always_comb begin
        mem_wrEn   = 1'b0;
        mem_addr   = r_last_addr;
        mem_dataIn = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_gnt[i]) begin
                mem_wrEn   = bus.we[i];
                mem_addr   = bus.addr[i*ADDR_W +: ADDR_W];
                mem_dataIn = bus.wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    // Arbitration state, lock tracking and the one-stage read tag pipeline
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr       <= IDX_W'(N_REQ - 1);
            r_owner     <= '0;
            r_lock_vld  <= 1'b0;
            r_burst_cnt <= '0;
            r_last_addr <= '0;
            r_rvalid    <= '0;
        end else begin
            r_rvalid <= w_gnt & ~bus.we;
            if (w_any) begin
                r_ptr       <= w_gnt_idx;
                r_owner     <= w_gnt_idx;
                r_lock_vld  <= bus.lock[w_gnt_idx];
                r_last_addr <= mem_addr;
                if (w_hold) begin
                    r_burst_cnt <= (r_burst_cnt >= BURST_CAP) ? r_burst_cnt
                                                              : r_burst_cnt + 1'b1;
                end else begin
                    r_burst_cnt <= '0;
                end
            end else begin
                r_lock_vld  <= 1'b0;
                r_burst_cnt <= '0;
            end
        end
    end

    // A read in flight when reset arrives is dropped, even in the reset cycle
    assign w_rvalid   = r_rvalid & {N_REQ{~rst}};
    assign bus.gnt    = w_gnt;
    assign bus.rvalid = w_rvalid;
    assign bus.rdata  = mem_dataOut;
    assign bus.busy   = w_any | (|w_rvalid);

endmodule : dmem_port_arbiter
`default_nettype wire

// File: tb/tb_dmem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_port_arbiter
//  Description : Directed self-checking bench for dmem_port_arbiter with a
//                behavioural 1-cycle registered-read RAM. Unwritten words read
//                as {12'hABC, 36'h0, addr}.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_dmem_port_arbiter;
    import dmem_arb_pkg::*;

    localparam int N  = 3;
    localparam int AW = 12;
    localparam int DW = 60;

    logic          clk = 1'b0;
    logic          rst;
    logic          mem_wrEn;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_dataIn;
    logic [DW-1:0] mem_dataOut;

    int n_cmp = 0;
    int n_err = 0;

    dmem_port_arbiter_if #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

    dmem_port_arbiter #(
        .N_REQ       (N),
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .MAX_BURST   (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .mem_wrEn    (mem_wrEn),
        .mem_addr    (mem_addr),
        .mem_dataIn  (mem_dataIn),
        .mem_dataOut (mem_dataOut)
    );

    always #5 clk = ~clk;

    // Behavioural RAM: write at the edge, registered read
    logic [DW-1:0]  ram [0:4095];
    logic [4095:0]  ram_wr;
    always @(posedge clk) begin
        if (rst) ram_wr <= '0;
        else if (mem_wrEn) begin
            ram[mem_addr]    <= mem_dataIn;
            ram_wr[mem_addr] <= 1'b1;
        end
        mem_dataOut <= (!rst && ram_wr[mem_addr]) ? ram[mem_addr] : {12'hABC, 36'h0, mem_addr};
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; bus.en = 3'b111; bus.req = 3'b111; bus.lock = '0; bus.we = '0;
        bus.addr = {12'h0AA, 12'h0BB, 12'h0CC}; bus.wdata = '0;
        tick(); settle();
        n_cmp++; if (bus.gnt !== 3'b000) begin n_err++; $display("FAIL reset_gnt: got %b expected 000", bus.gnt); end
        n_cmp++; if (bus.rvalid !== 3'b000) begin n_err++; $display("FAIL reset_rvalid: got %b expected 000", bus.rvalid); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        n_cmp++; if (mem_wrEn !== 1'b0) begin n_err++; $display("FAIL reset_wren: got %b expected 0", mem_wrEn); end
        n_cmp++; if (mem_addr !== 12'h000) begin n_err++; $display("FAIL reset_addr: got %h expected 000", mem_addr); end
        tick(); rst = 1'b0; bus.req = '0; settle();
        n_cmp++; if (bus.gnt !== 3'b000) begin n_err++; $display("FAIL idle_gnt: got %b expected 000", bus.gnt); end
    endtask

    task automatic test_contention();
        logic [2:0] exp_g;
        logic [2:0] prev_g;
        tick(); bus.req = 3'b111; bus.en = 3'b111; bus.we = '0;
        bus.addr = {12'h012, 12'h011, 12'h010};
        prev_g = '0;
        for (int k = 0; k < 6; k++) begin
            settle();
            exp_g = 3'b001 << (k % 3);
            n_cmp++; if (bus.gnt !== exp_g) begin n_err++; $display("FAIL rr_gnt[%0d]: got %b expected %b", k, bus.gnt, exp_g); end
            n_cmp++; if (mem_addr !== 12'(16 + (k % 3))) begin n_err++; $display("FAIL rr_addr[%0d]: got %h expected %h", k, mem_addr, 12'(16 + (k % 3))); end
            if (k > 0) begin
                n_cmp++; if (bus.rvalid !== prev_g) begin n_err++; $display("FAIL rr_rvalid[%0d]: got %b expected %b", k, bus.rvalid, prev_g); end
                n_cmp++; if (bus.rdata !== {12'hABC, 36'h0, 12'(16 + ((k - 1) % 3))}) begin n_err++; $display("FAIL rr_rdata[%0d]: got %h", k, bus.rdata); end
            end
            prev_g = exp_g;
            tick();
        end
        bus.req = '0; settle();
        n_cmp++; if (bus.rvalid !== 3'b100) begin n_err++; $display("FAIL rr_last_rvalid: got %b expected 100", bus.rvalid); end
        n_cmp++; if (bus.rdata !== 60'hABC000000000012) begin n_err++; $display("FAIL rr_last_rdata: got %h expected ABC000000000012", bus.rdata); end
        // Pointer left at 2: requester 0 wins the next tie
        tick(); bus.req = 3'b011; settle();
        n_cmp++; if (bus.gnt !== 3'b001) begin n_err++; $display("FAIL rr_ptr_end: got %b expected 001", bus.gnt); end
        tick(); bus.req = '0;
    endtask

    task automatic test_single();
        tick(); bus.req = 3'b010; bus.we = '0; bus.addr = {12'h000, 12'h005, 12'h000}; settle();
        n_cmp++; if (bus.gnt !== 3'b010) begin n_err++; $display("FAIL single_gnt: got %b expected 010", bus.gnt); end
        n_cmp++; if (mem_addr !== 12'h005) begin n_err++; $display("FAIL single_addr: got %h expected 005", mem_addr); end
        n_cmp++; if (mem_wrEn !== 1'b0) begin n_err++; $display("FAIL single_wren: got %b expected 0", mem_wrEn); end
        tick(); bus.req = '0; bus.addr = '0; settle();
        n_cmp++; if (bus.rvalid !== 3'b010) begin n_err++; $display("FAIL single_rvalid: got %b expected 010", bus.rvalid); end
        n_cmp++; if (bus.rdata !== 60'hABC000000000005) begin n_err++; $display("FAIL single_rdata: got %h expected ABC000000000005", bus.rdata); end
        n_cmp++; if (mem_addr !== 12'h005) begin n_err++; $display("FAIL single_addr_hold: got %h expected 005", mem_addr); end
        n_cmp++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL single_busy: got %b expected 1", bus.busy); end
        tick(); settle();
        n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL single_idle_busy: got %b expected 0", bus.busy); end
    endtask

    task automatic test_burst();
        logic [2:0] exp_g;
        tick(); bus.req = 3'b011; bus.lock = 3'b001; bus.addr = {12'h022, 12'h021, 12'h020};
        for (int k = 0; k < 7; k++) begin
            settle();
            exp_g = (k == 4) ? 3'b010 : 3'b001;
            n_cmp++; if (bus.gnt !== exp_g) begin n_err++; $display("FAIL burst_gnt[%0d]: got %b expected %b", k, bus.gnt, exp_g); end
            tick();
        end
        // Owner drops its request: lock released in the same cycle
        bus.req = 3'b010; settle();
        n_cmp++; if (bus.gnt !== 3'b010) begin n_err++; $display("FAIL burst_release: got %b expected 010", bus.gnt); end
        tick(); bus.req = '0; bus.lock = '0;
    endtask

    task automatic test_enable_mask();
        tick(); bus.en = 3'b010; bus.req = 3'b111; bus.we = 3'b010;
        bus.addr = {12'h030, 12'h007, 12'h030};
        bus.wdata = {60'hFFF, 60'h123, 60'hFFF};
        for (int k = 0; k < 3; k++) begin
            settle();
            n_cmp++; if (bus.gnt !== 3'b010) begin n_err++; $display("FAIL mask_gnt[%0d]: got %b expected 010", k, bus.gnt); end
            n_cmp++; if ({mem_wrEn, mem_addr} !== {1'b1, 12'h007}) begin n_err++; $display("FAIL mask_wr[%0d]: got %b/%h expected 1/007", k, mem_wrEn, mem_addr); end
            n_cmp++; if (mem_dataIn !== 60'h123) begin n_err++; $display("FAIL mask_wdata[%0d]: got %h expected 123", k, mem_dataIn); end
            tick();
        end
        bus.en = 3'b000; settle();
        n_cmp++; if (bus.gnt !== 3'b000) begin n_err++; $display("FAIL mask_none_gnt: got %b expected 000", bus.gnt); end
        n_cmp++; if (bus.rvalid !== 3'b000) begin n_err++; $display("FAIL mask_write_rvalid: got %b expected 000", bus.rvalid); end
        n_cmp++; if ({mem_wrEn, mem_addr, mem_dataIn} !== {1'b0, 12'h007, 60'h0}) begin n_err++; $display("FAIL mask_park: got %b/%h/%h expected 0/007/0", mem_wrEn, mem_addr, mem_dataIn); end
        tick(); bus.en = 3'b100; bus.we = '0; bus.addr = {12'h007, 12'h000, 12'h000}; settle();
        n_cmp++; if (bus.gnt !== 3'b100) begin n_err++; $display("FAIL mask_tx_gnt: got %b expected 100", bus.gnt); end
        tick(); bus.req = '0; bus.en = 3'b111; settle();
        n_cmp++; if (bus.rvalid !== 3'b100) begin n_err++; $display("FAIL mask_tx_rvalid: got %b expected 100", bus.rvalid); end
        n_cmp++; if (bus.rdata !== 60'h123) begin n_err++; $display("FAIL mask_tx_rdata: got %h expected 123", bus.rdata); end
    endtask

    task automatic test_back_to_back();
        tick(); bus.req = 3'b001; bus.addr = {12'h000, 12'h000, 12'h001}; settle();
        n_cmp++; if (bus.gnt !== 3'b001) begin n_err++; $display("FAIL b2b_gnt0: got %b expected 001", bus.gnt); end
        tick(); bus.req = 3'b100; bus.en = 3'b110; bus.addr = {12'h002, 12'h000, 12'h000}; settle();
        n_cmp++; if (bus.gnt !== 3'b100) begin n_err++; $display("FAIL b2b_gnt2: got %b expected 100", bus.gnt); end
        n_cmp++; if (bus.rvalid !== 3'b001) begin n_err++; $display("FAIL b2b_rvalid0: got %b expected 001", bus.rvalid); end
        n_cmp++; if (bus.rdata !== 60'hABC000000000001) begin n_err++; $display("FAIL b2b_rdata0: got %h expected ABC000000000001", bus.rdata); end
        tick(); bus.req = '0; bus.en = 3'b111; settle();
        n_cmp++; if (bus.rvalid !== 3'b100) begin n_err++; $display("FAIL b2b_rvalid2: got %b expected 100", bus.rvalid); end
        n_cmp++; if (bus.rdata !== 60'hABC000000000002) begin n_err++; $display("FAIL b2b_rdata2: got %h expected ABC000000000002", bus.rdata); end
    endtask

    task automatic test_reset_mid_read();
        tick(); bus.req = 3'b001; bus.addr = {12'h000, 12'h000, 12'h003}; settle();
        n_cmp++; if (bus.gnt !== 3'b001) begin n_err++; $display("FAIL rmr_gnt: got %b expected 001", bus.gnt); end
        tick(); rst = 1'b1; bus.req = '0; settle();
        n_cmp++; if (bus.rvalid !== 3'b000) begin n_err++; $display("FAIL rmr_rvalid_rst: got %b expected 000", bus.rvalid); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL rmr_busy_rst: got %b expected 0", bus.busy); end
        tick(); rst = 1'b0; settle();
        n_cmp++; if (bus.rvalid !== 3'b000) begin n_err++; $display("FAIL rmr_rvalid_after: got %b expected 000", bus.rvalid); end
        tick(); bus.req = 3'b011; settle();
        n_cmp++; if (bus.gnt !== 3'b001) begin n_err++; $display("FAIL rmr_ptr_reset: got %b expected 001", bus.gnt); end
        tick(); bus.req = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_contention();
        test_single();
        test_burst();
        test_enable_mask();
        test_back_to_back();
        test_reset_mid_read();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_dmem_port_arbiter
`default_nettype wire
